// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// load/store. Data accesses win by default; a wait counter lets fetch win after
// MAX_WAIT consecutive lost cycles. Read data returns one cycle after grant to
// the requester that issued the read.
//
// Handshake: a requester raises *_req with a stable payload. *_gnt is high in
// the same cycle when the request is accepted. Until then the requester keeps
// req and payload unchanged. It may drop an ungranted request, and dropping it
// has no side effect. Reads answer with *_rvalid exactly one cycle after
// *_gnt. Writes complete at grant and never answer.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_en,
    output logic                mem_read_req,
    output logic                mem_write_req,
    input  logic [DATA_W-1:0]   mem_rdata_raw,
    output logic [3:0]          dbg_wait_cnt,
    output logic [1:0]          dbg_resp_owner
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    owner_t     resp_owner, resp_owner_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       fetch_win, data_win;

    // Pick the winner: fetch when uncontended or when it has starved long enough.
    always_comb begin
        fetch_win = i_req && (!d_req || (wait_cnt == WAIT_LIMIT));
        data_win  = d_req && !fetch_win;
    end

    assign i_gnt = fetch_win;
    assign d_gnt = data_win;

    // Drive the memory port from the winner. All fields are zero when idle.
    always_comb begin
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_byte_en   = '0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        if (fetch_win) begin
            mem_addr     = i_addr;
            mem_byte_en  = '1;
            mem_read_req = 1'b1;
        end else if (data_win) begin
            mem_addr      = d_addr;
            mem_wdata     = d_wdata;
            mem_byte_en   = d_be;
            mem_read_req  = !d_we;
            mem_write_req = d_we;
        end
    end

    // Next starvation count and next response owner.
    always_comb begin
        wait_cnt_nxt   = wait_cnt;
        resp_owner_nxt = OWN_NONE;
        if (!i_req || fetch_win) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt < WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
        end
        if (fetch_win) begin
            resp_owner_nxt = OWN_INST;
        end else if (data_win && !d_we) begin
            resp_owner_nxt = OWN_DATA;
        end
    end

    // State registers. An asynchronous reset discards any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= '0;
            resp_owner <= OWN_NONE;
        end else begin
            wait_cnt   <= wait_cnt_nxt;
            resp_owner <= resp_owner_nxt;
        end
    end

    // Route the returning read data to the owner and zero the other side.
    assign i_rvalid = (resp_owner == OWN_INST);
    assign d_rvalid = (resp_owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? mem_rdata_raw : '0;
    assign d_rdata  = d_rvalid ? mem_rdata_raw : '0;

    assign dbg_wait_cnt   = wait_cnt;
    assign dbg_resp_owner = resp_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_read_req, mem_write_req;
  logic [31:0] mem_rdata_raw;
  logic [3:0]  dbg_wait_cnt;
  logic [1:0]  dbg_resp_owner;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_rdata_raw(mem_rdata_raw),
    .dbg_wait_cnt(dbg_wait_cnt), .dbg_resp_owner(dbg_resp_owner)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory (environment) ----------------
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  initial begin
    mem_rdata_raw = '0;
    for (int k = 0; k < 256; k++) begin
      mem[k] = '0;
      ref_mem[k] = '0;
    end
    mem[0] = 32'h0000_0013; ref_mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093; ref_mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113; ref_mem[2] = 32'h0020_0113;
  end

  always @(posedge clk) begin
    if (mem_read_req) mem_rdata_raw <= mem[mem_addr[9:2]];
    if (mem_write_req)
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // lost_streak: consecutive cycles fetch asked and lost (capped at MAX_WAIT).
  // pend_who: 0 none, 1 fetch, 2 data -- who receives data this cycle.
  int          lost_streak = 0;
  int          pend_who = 0;
  logic [31:0] pend_data = '0;
  logic        last_i_gnt = 1'b0;
  logic        last_d_gnt = 1'b0;

  always @(negedge clk) begin
    logic        e_i, e_d;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_rd, e_wr;
    if (!rst) begin
      lost_streak = 0;
      pend_who = 0;
      pend_data = '0;
    end
    e_i = i_req && (!d_req || lost_streak >= MAX_WAIT);
    e_d = d_req && !e_i;
    e_addr = e_i ? i_addr : (e_d ? d_addr : 32'h0);
    e_wdata = e_d ? d_wdata : 32'h0;
    e_be = e_i ? 4'hF : (e_d ? d_be : 4'h0);
    e_rd = e_i || (e_d && !d_we);
    e_wr = e_d && d_we;

    chk("i_gnt", i_gnt, e_i);
    chk("d_gnt", d_gnt, e_d);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_byte_en", mem_byte_en, e_be);
    chk("mem_read_req", mem_read_req, e_rd);
    chk("mem_write_req", mem_write_req, e_wr);
    chk("i_rvalid", i_rvalid, pend_who == 1);
    chk("i_rdata", i_rdata, (pend_who == 1) ? pend_data : 32'h0);
    chk("d_rvalid", d_rvalid, pend_who == 2);
    chk("d_rdata", d_rdata, (pend_who == 2) ? pend_data : 32'h0);
    chk("wait_cnt", dbg_wait_cnt, lost_streak);

    last_i_gnt = e_i;
    last_d_gnt = e_d;

    // Writes land in memory regardless of reset; memory is not reset.
    if (e_wr)
      for (int b = 0; b < 4; b++)
        if (d_be[b]) ref_mem[d_addr[9:2]][b*8 +: 8] = d_wdata[b*8 +: 8];

    if (!rst) begin
      pend_who = 0;
      lost_streak = 0;
    end else begin
      pend_who = e_i ? 1 : ((e_d && !d_we) ? 2 : 0);
      if (e_i) pend_data = ref_mem[i_addr[9:2]];
      else if (e_d && !d_we) pend_data = ref_mem[d_addr[9:2]];
      if (i_req && !e_i) lost_streak = (lost_streak < MAX_WAIT) ? lost_streak + 1 : MAX_WAIT;
      else lost_streak = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] fetch_exp [3];
    fetch_exp[0] = 32'h0000_0013;
    fetch_exp[1] = 32'h0010_0093;
    fetch_exp[2] = 32'h0020_0113;

    rst = 1'b1;
    idle();
    #1 rst = 1'b0;

    // Reset held with a fetch request pending.
    i_req = 1; i_addr = 32'h0;
    sample();
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_i_gnt_comb", i_gnt, 1'b1);
    tick();
    rst = 1'b1;
    sample();
    chk("rel_i_gnt", i_gnt, 1'b1);
    tick();
    i_req = 0;
    sample();
    chk("rel_i_rvalid", i_rvalid, 1'b1);
    chk("rel_i_rdata", i_rdata, 32'h0000_0013);

    // Fetch back-to-back at 0x0, 0x4, 0x8.
    for (int k = 0; k < 5; k++) begin
      tick();
      i_req = (k < 3);
      i_addr = (k < 3) ? 32'(k * 4) : 32'h0;
      sample();
      chk("fetch_gnt", i_gnt, k < 3);
      chk("fetch_rvalid", i_rvalid, (k >= 1 && k <= 3));
      if (k >= 1 && k <= 3) chk("fetch_rdata", i_rdata, fetch_exp[k-1]);
    end

    // Store then load at 0x100.
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    sample();
    chk("st_write_req", mem_write_req, 1'b1);
    chk("st_d_gnt", d_gnt, 1'b1);
    tick();
    d_we = 0;
    sample();
    chk("ld_no_resp_for_store", d_rvalid, 1'b0);
    chk("ld_read_req", mem_read_req, 1'b1);
    tick();
    idle();
    sample();
    chk("ld_d_rvalid", d_rvalid, 1'b1);
    chk("ld_d_rdata", d_rdata, 32'h0000_BEEF);

    // Contention for 10 cycles from an idle start.
    tick();
    sample();
    for (int k = 0; k < 10; k++) begin
      tick();
      i_req = 1; i_addr = 32'h8;
      d_req = 1; d_we = 0; d_addr = 32'h4; d_be = 4'hF;
      sample();
      chk("cont_i_gnt", i_gnt, (k == 4 || k == 9));
      chk("cont_d_gnt", d_gnt, !(k == 4 || k == 9));
      chk("cont_wait_cnt", dbg_wait_cnt, 4'(k % 5));
    end
    tick();
    idle();
    sample();

    // Response routing: fetch then data read.
    tick();
    i_req = 1; i_addr = 32'h4;
    sample();
    chk("route_i_gnt", i_gnt, 1'b1);
    tick();
    i_req = 0; d_req = 1; d_we = 0; d_addr = 32'h8; d_be = 4'hF;
    sample();
    chk("route_d_gnt", d_gnt, 1'b1);
    chk("route_i_rvalid1", i_rvalid, 1'b1);
    chk("route_d_rvalid1", d_rvalid, 1'b0);
    tick();
    idle();
    sample();
    chk("route_i_rvalid2", i_rvalid, 1'b0);
    chk("route_i_rdata2", i_rdata, 32'h0);
    chk("route_d_rvalid2", d_rvalid, 1'b1);
    chk("route_d_rdata2", d_rdata, 32'h0020_0113);

    // Reset in the middle of a data read, with the counter non-zero.
    for (int k = 0; k < 3; k++) begin
      tick();
      i_req = 1; i_addr = 32'h0;
      d_req = 1; d_we = 0; d_addr = 32'h0; d_be = 4'hF;
      sample();
    end
    chk("mid_d_gnt", d_gnt, 1'b1);
    chk("mid_wait_before", dbg_wait_cnt, 4'd2);
    tick();
    idle();
    #1 rst = 1'b0;
    sample();
    chk("mid_d_rvalid", d_rvalid, 1'b0);
    chk("mid_wait_cnt", dbg_wait_cnt, 4'd0);
    tick();
    rst = 1'b1;
    sample();

    // Randomized traffic; an ungranted request is normally held stable.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      if (!(i_req && !last_i_gnt && $urandom_range(0, 9) != 0)) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!(d_req && !last_d_gnt && $urandom_range(0, 9) != 0)) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = 32'($urandom_range(0, 255)) << 2;
        d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15));
      end
    end
    tick();
    rst = 1'b1;
    idle();
    sample();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported `mmodel` memory between the core's instruction-fetch path and its load/store path, for the unified-memory core variant. Each cycle it grants at most one requester and drives the memory port from that requester. It returns read data one cycle later to the requester that issued the read. Data accesses have priority; a wait counter bounds instruction-fetch starvation.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte-enable width is `DATA_W/8`)
- `MAX_WAIT`, 4, consecutive lost-arbitration cycles after which fetch wins; range 1..15

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `i_req` in 1: fetch read request
- `i_addr` in ADDR_W: fetch address
- `i_gnt` out 1: fetch accepted this cycle
- `i_rvalid` out 1: fetch data valid
- `i_rdata` out DATA_W: fetch data
- `d_req` in 1: data request
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: write data
- `d_be` in DATA_W/8: byte enables
- `d_gnt` out 1: data request accepted this cycle
- `d_rvalid` out 1: load data valid (reads only)
- `d_rdata` out DATA_W: load data
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_byte_en` out DATA_W/8, `mem_read_req` out 1, `mem_write_req` out 1: memory port
- `mem_rdata_raw` in DATA_W: memory read data, valid the cycle after `mem_read_req`

## Operation
- Arbitration is combinational on the current inputs and registered `wait_cnt`:
  - Fetch wins if `i_req` is asserted and either `d_req`=0 or `wait_cnt`==`MAX_WAIT`.
  - Otherwise data wins if `d_req` is asserted.
  - Exactly one of `i_gnt`/`d_gnt` may be high; both are low when neither requests.
- The winning requester drives the memory port:
  - Fetch winner: `mem_addr`=`i_addr`, `mem_read_req`=1, `mem_byte_en`=all ones, `mem_wdata`=0.
  - Data winner: `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`, `mem_byte_en`=`d_be`. `mem_read_req`=!`d_we` and `mem_write_req`=`d_we`.
  - No grant: all memory outputs are 0.
- A requester that is not granted holds its request and payload stable until granted. Dropping a request before grant is legal and has no effect.
- `wait_cnt` (4 bits, registered):
  - +1 each cycle `i_req`=1 and `i_gnt`=0, saturating at `MAX_WAIT`.
  - Cleared on `i_gnt`=1 or `i_req`=0.
- Response tracking uses registered `resp_owner`, with values NONE, INST, DATA:
  - Set to INST on a fetch grant, DATA on a data read grant, NONE otherwise (including data writes).
  - `i_rvalid` = (`resp_owner`==INST); `d_rvalid` = (`resp_owner`==DATA).
  - `i_rdata`/`d_rdata` = `mem_rdata_raw` when the matching rvalid is high, else 0.
- Writes complete at grant and produce no response.
- The back-to-back path has no bubble: a new grant may coincide with the response of the previous read.

## Timing
- Grant: 0-cycle latency, same cycle as the request.
- Read data: exactly 1 cycle after grant. Throughput is one access per cycle.
- Reset (`rst`=0, asynchronous): `wait_cnt`=0 and `resp_owner`=NONE, so `i_rvalid`=`d_rvalid`=0 and `i_rdata`=`d_rdata`=0. The combinational outputs follow their inputs.
  - A read granted in the cycle reset asserts never produces a response.
- Simultaneous requests with `wait_cnt`<`MAX_WAIT`: data wins and `wait_cnt` increments.
  - With continuous `d_req` and `i_req`, fetch is granted on every (`MAX_WAIT`+1)-th cycle.
- Saturation: `wait_cnt` never exceeds `MAX_WAIT`.
  - Grant decisions are identical whether the counter reached `MAX_WAIT` through saturation or exactly.

## Test plan
- Reset: hold `rst`=0 with `i_req`=1 → `i_rvalid`=0 and `i_rdata`=0. Release reset → `i_gnt`=1 the same cycle, and `i_rvalid`=1 with `i_rdata`=mem[`i_addr`] the next cycle.
- Fetch only: `i_req` at addresses 0x0, 0x4, 0x8 back-to-back → 3 consecutive grants. `i_rvalid` is high for 3 cycles starting one cycle later, with data 0x00000013, 0x00100093, 0x00200113 (preloaded).
- Store then load: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011 → `mem_write_req`=1 and no `d_rvalid`. Next cycle `d_we`=0 at 0x100 → following cycle `d_rvalid`=1 and `d_rdata`=0x0000BEEF (memory zero-initialised).
- Contention, `MAX_WAIT`=4: `i_req` and `d_req` held high for 10 cycles → `d_gnt` in cycles 0-3, `i_gnt` in cycle 4, `d_gnt` in cycles 5-8, `i_gnt` in cycle 9. `wait_cnt` sequence: 1, 2, 3, 4, 0, …
- Response routing: fetch grant at cycle 0, data read grant at cycle 1 → `i_rvalid` only at cycle 1 and `d_rvalid` only at cycle 2. `i_rdata` is 0 at cycle 2.
- Reset mid-access: data read granted, then `rst`=0 asynchronously before the next edge → `d_rvalid` stays 0 and `wait_cnt`=0.
